// File: rtl/memory_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage_pkg                                                     |
// | Shared encodings, default widths and FSM state type for the memory   |
// | pipeline stage.                                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package memory_stage_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDD  = 3'b001;
  localparam logic [2:0] OP_STD  = 3'b010;
  localparam logic [2:0] OP_PUSH = 3'b011;
  localparam logic [2:0] OP_POP  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  // CALL and RET move a 32-bit PC through two 16-bit stack words.
  function automatic logic is_two_cycle(input logic [2:0] op);
    return (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_memory                                                          |
// | Single-port data RAM: synchronous write, registered read, no reset.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module data_memory #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // One access per cycle; the read register only moves when a read is requested.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage                                                         |
// | MEM pipeline stage: loads/stores, descending stack PUSH/POP, two-    |
// | cycle CALL/RET PC transfer, stack pointer and MEM/WB register.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SP_RESET = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [2:0]        memOp,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] storeData,
  input  logic [31:0]       pcIn,
  input  logic [2:0]        rdIn,
  input  logic              regWriteIn,
  output logic              stall,
  output logic              valid_out,
  output logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [2:0]        rdOut,
  output logic              regWriteOut,
  output logic [31:0]       pcOut,
  output logic              pcOutValid,
  output logic              memErr,
  output logic              stackErr,
  output logic [ADDR_W-1:0] sp
);

  localparam logic [ADDR_W-1:0] SP_RST   = ADDR_W'(SP_RESET);
  // Popping k words underflows when SP >= SP_RESET-k+1.
  localparam logic [ADDR_W-1:0] POP1_LIM = ADDR_W'(SP_RESET);
  localparam logic [ADDR_W-1:0] POP2_LIM = ADDR_W'(SP_RESET - 1);

  state_t            state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] pc_lo_q;
  logic              err_q;
  logic [2:0]        rd_q;
  logic              rw_q;
  logic [DATA_W-1:0] alu_q;
  logic              load_q;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              adr_err;
  logic              pop1_err;
  logic              pop2_err;
  logic              mem_err_now;
  logic              stk_err_now;

  assign adr_err     = |(aluResult >> ADDR_W);
  assign pop1_err    = (sp >= POP1_LIM);
  assign pop2_err    = (sp >= POP2_LIM);
  assign mem_err_now = valid_in && ((memOp == OP_LDD) || (memOp == OP_STD)) && adr_err;
  assign stk_err_now = valid_in && (memOp == OP_POP) && pop1_err;

  assign stall   = (state == ST_IDLE) && valid_in && is_two_cycle(memOp);
  // Load data and the popped PC come straight off the RAM read register,
  // gated so they read as zero outside their result cycle.
  assign memData = load_q ? mem_rdata : '0;
  assign pcOut   = pcOutValid ? {mem_rdata[15:0], pc_lo_q[15:0]} : 32'h0;

  // RAM port steering: first word in IDLE from live inputs, second word from latched op.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = sp;
    mem_wdata = storeData;
    if (state == ST_IDLE) begin
      if (valid_in) begin
        case (memOp)
          OP_LDD: begin
            mem_addr = aluResult[ADDR_W-1:0];
            mem_re   = !adr_err;
          end
          OP_STD: begin
            mem_addr = aluResult[ADDR_W-1:0];
            mem_we   = !adr_err;
          end
          OP_PUSH: mem_we = 1'b1;
          OP_POP: begin
            mem_addr = sp + ADDR_W'(1);
            mem_re   = !pop1_err;
          end
          OP_CALL: begin
            mem_we    = 1'b1;
            mem_wdata = DATA_W'(pcIn[31:16]);
          end
          OP_RET: begin
            mem_addr = sp + ADDR_W'(1);
            mem_re   = !pop2_err;
          end
          default: ;
        endcase
      end
    end else begin
      if (op_q == OP_CALL) begin
        mem_we    = 1'b1;
        mem_addr  = sp - ADDR_W'(1);
        mem_wdata = pc_lo_q;
      end else begin
        mem_addr = sp + ADDR_W'(2);
        mem_re   = !err_q;
      end
    end
  end

  data_memory #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // Control FSM, stack pointer and MEM/WB payload register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sp           <= SP_RST;
      op_q         <= OP_NOP;
      pc_lo_q      <= '0;
      err_q        <= 1'b0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      alu_q        <= '0;
      load_q       <= 1'b0;
      valid_out    <= 1'b0;
      aluResultOut <= '0;
      rdOut        <= '0;
      regWriteOut  <= 1'b0;
      memErr       <= 1'b0;
      stackErr     <= 1'b0;
      pcOutValid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          aluResultOut <= aluResult;
          rdOut        <= rdIn;
          pcOutValid   <= 1'b0;
          if (stall) begin
            // Latch everything the second cycle needs; upstream may change inputs.
            state       <= ST_SECOND;
            op_q        <= memOp;
            pc_lo_q     <= DATA_W'(pcIn[15:0]);
            err_q       <= (memOp == OP_RET) && pop2_err;
            rd_q        <= rdIn;
            rw_q        <= regWriteIn;
            alu_q       <= aluResult;
            load_q      <= 1'b0;
            valid_out   <= 1'b0;
            regWriteOut <= 1'b0;
            memErr      <= 1'b0;
            stackErr    <= 1'b0;
          end else begin
            valid_out   <= valid_in;
            memErr      <= mem_err_now;
            stackErr    <= stk_err_now;
            regWriteOut <= valid_in && regWriteIn && !mem_err_now && !stk_err_now;
            load_q      <= valid_in && (((memOp == OP_LDD) && !adr_err) ||
                                        ((memOp == OP_POP) && !pop1_err));
            if (valid_in && (memOp == OP_PUSH)) begin
              sp <= sp - ADDR_W'(1);
            end else if (valid_in && (memOp == OP_POP) && !pop1_err) begin
              sp <= sp + ADDR_W'(1);
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          valid_out    <= 1'b1;
          aluResultOut <= alu_q;
          rdOut        <= rd_q;
          memErr       <= 1'b0;
          load_q       <= 1'b0;
          stackErr     <= err_q;
          regWriteOut  <= rw_q && !err_q;
          if (op_q == OP_CALL) begin
            sp         <= sp - ADDR_W'(2);
            pcOutValid <= 1'b0;
          end else begin
            // Low half was read in the first cycle; high half lands in the RAM register now.
            pc_lo_q    <= mem_rdata;
            pcOutValid <= !err_q;
            if (!err_q) begin
              sp <= sp + ADDR_W'(2);
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
